// File: rtl/activity_monitor_bank.sv
// Multi-channel activity monitor: per-channel event counters with optional windowed snapshots.
// Define ACTMON_THRESH_EN to add the per-channel snapshot threshold compare (thresh / thresh_hit).
module activity_monitor_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SIG_W  = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned WIN_W  = 16,
  localparam int unsigned RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*SIG_W-1:0] sig_in,
  input  logic [2*NUM_CH-1:0]     ch_mode,
  input  logic                    clear,
  input  logic                    win_en,
  input  logic [WIN_W-1:0]        win_len,
`ifdef ACTMON_THRESH_EN
  input  logic [CNT_W-1:0]        thresh,
  output logic [NUM_CH-1:0]       thresh_hit,
`endif
  output logic                    snap_valid,
  output logic [NUM_CH-1:0]       ovf,
  input  logic                    rd_en,
  input  logic                    rd_src,
  input  logic [RD_W-1:0]         rd_ch,
  output logic                    rd_valid,
  output logic [CNT_W-1:0]        rd_data
);

  localparam logic [1:0] MODE_CHANGE = 2'd0;
  localparam logic [1:0] MODE_LEVEL  = 2'd1;
  localparam logic [1:0] MODE_RISE   = 2'd2;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic                   win_term;

  logic [SIG_W-1:0]       prev_q [NUM_CH];
  logic [CNT_W-1:0]       cnt_q  [NUM_CH];
  logic [CNT_W-1:0]       cnt_d  [NUM_CH];
  logic [CNT_W-1:0]       cnt_inc[NUM_CH];
  logic [CNT_W-1:0]       snap_q [NUM_CH];
  logic [CNT_W-1:0]       snap_d [NUM_CH];
  logic [NUM_CH-1:0]      ev;
  logic [NUM_CH-1:0]      sat_hit;
  logic [NUM_CH-1:0]      ovf_q, ovf_d;
  logic                   snap_valid_q;
  logic                   rd_valid_q;
  logic [CNT_W-1:0]       rd_data_q, rd_data_d, rd_val;

  // Per-channel event detection against the previous registered sample
  always_comb begin
    ev = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (ch_mode[2*i +: 2])
        MODE_CHANGE: ev[i] = (sig_in[i*SIG_W +: SIG_W] != prev_q[i]);
        MODE_LEVEL:  ev[i] = sig_in[i*SIG_W];
        MODE_RISE:   ev[i] = sig_in[i*SIG_W] & ~prev_q[i][0];
        default:     ev[i] = 1'b0;
      endcase
    end
  end

  // Saturating increment; an event arriving at all-ones is lost and flagged
  always_comb begin
    sat_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (ev[i]) begin
        if (cnt_q[i] == {CNT_W{1'b1}}) sat_hit[i] = 1'b1;
        else                           cnt_inc[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Window FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Window FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_en && (win_len != '0)) state_d = S_RUN;
      S_RUN:  if (!win_en || (win_len == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window FSM: counter and terminal detect; >= handles win_len shrinking mid-window
  always_comb begin
    win_cnt_d = '0;
    win_term  = 1'b0;
    if ((state_q == S_RUN) && win_en && (win_len != '0)) begin
      if (win_cnt_q >= (win_len - WIN_W'(1))) win_term = 1'b1;
      else                                    win_cnt_d = win_cnt_q + WIN_W'(1);
    end
    if (clear) begin
      win_cnt_d = '0;
      win_term  = 1'b0;
    end
  end

  // Live counters, snapshots and sticky overflow
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_inc[i];
      snap_d[i] = snap_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (win_term) begin
        cnt_d[i]  = '0;
        snap_d[i] = cnt_inc[i];
      end
    end
    ovf_d = clear ? '0 : (ovf_q | sat_hit);
  end

  // Read mux samples pre-update register contents
  always_comb begin
    rd_val = '0;
    if (32'(rd_ch) < NUM_CH) rd_val = rd_src ? snap_q[rd_ch] : cnt_q[rd_ch];
    rd_data_d = rd_en ? rd_val : rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      win_cnt_q    <= '0;
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= sig_in[i*SIG_W +: SIG_W];
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
      win_cnt_q    <= win_cnt_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= win_term;
      rd_valid_q   <= rd_en;
      rd_data_q    <= rd_data_d;
    end
  end

`ifdef ACTMON_THRESH_EN
  logic [NUM_CH-1:0] thr_q, thr_d;

  // Threshold flags refresh alongside each snapshot
  always_comb begin
    thr_d = thr_q;
    if (clear) begin
      thr_d = '0;
    end else if (win_term) begin
      for (int i = 0; i < NUM_CH; i++) thr_d[i] = (cnt_inc[i] >= thresh);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) thr_q <= '0;
    else       thr_q <= thr_d;
  end

  assign thresh_hit = thr_q;
`endif

  assign snap_valid = snap_valid_q;
  assign ovf        = ovf_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

endmodule
